// File: rtl/axis_l4_splitter.sv
// IPv4 UDP/TCP splitter: parses headers from an AXI-Stream byte stream, buffers payload
// into a MAX_BYTES window and presents it on the matching L4 output channel.

module axis_l4_lane #(
    parameter int LANE = 0
) (
    input  logic [15:0] off,
    input  logic        keep,
    output logic [15:0] lane_off,
    output logic        hit_ver,
    output logic        hit_proto,
    output logic        hit_doff,
    output logic        hit_hdr
);
    logic [16:0] sum;

    assign sum       = {1'b0, off} + 17'(LANE);
    assign lane_off  = sum[16] ? 16'hFFFF : sum[15:0];
    assign hit_ver   = keep && (lane_off == 16'd0);
    assign hit_proto = keep && (lane_off == 16'd9);
    assign hit_doff  = keep && (lane_off == 16'd32);
    assign hit_hdr   = keep && (lane_off >= 16'd20) && (lane_off <= 16'd27);
endmodule

module axis_l4_splitter #(
    parameter int DATA_W    = 32,
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_in_tvalid,
    output logic                   io_in_tready,
    input  logic [DATA_W-1:0]      io_in_tdata,
    input  logic [DATA_W/8-1:0]    io_in_tkeep,
    input  logic                   io_in_tlast,
    output logic                   io_out_udp_valid,
    input  logic                   io_out_udp_ready,
    output logic [8*MAX_BYTES-1:0] io_out_udp_bits_data,
    output logic [15:0]            io_out_udp_bits_len,
    output logic [15:0]            io_out_udp_bits_udp_head_src_port,
    output logic [15:0]            io_out_udp_bits_udp_head_dst_port,
    output logic [15:0]            io_out_udp_bits_udp_head_length,
    output logic [15:0]            io_out_udp_bits_udp_head_checksum,
    output logic                   io_out_tcp_valid,
    input  logic                   io_out_tcp_ready,
    output logic [8*MAX_BYTES-1:0] io_out_tcp_bits_data,
    output logic [15:0]            io_out_tcp_bits_len,
    output logic [31:0]            io_out_tcp_bits_seq,
    output logic                   io_out_trunc,
    output logic [CNT_W-1:0]       io_drop_count
);
    localparam int          NB      = DATA_W / 8;
    localparam int          AW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [15:0] MAXB    = 16'(MAX_BYTES);
    localparam logic [15:0] UDP_END = 16'd28;
    localparam logic [15:0] TCP_END = 16'd40;
    localparam logic [7:0]  P_UDP   = 8'd17;
    localparam logic [7:0]  P_TCP   = 8'd6;

    typedef enum logic [1:0] {RECV, HOLD, DROP} state_t;
    state_t state, state_nx;

    logic [NB-1:0][7:0]           din;
    logic [NB-1:0][15:0]          lane_off, pay_idx;
    logic [NB-1:0]                hit_ver, hit_proto, hit_doff, hit_hdr, pay_hit;
    logic [MAX_BYTES-1:0][7:0]    pay_buf;
    logic [7:0][7:0]              hdr;
    logic [15:0]                  off, cnt, off_nx, hdr_end, len_r, diff;
    logic [16:0]                  off_sum;
    logic [7:0]                   proto_r, proto_eff;
    logic                         bad_r, bad_now, bad_eff, trunc_r;
    logic                         beat, cap, emit, drop_inc, release_hs;
    logic [CNT_W-1:0]             drop_cnt;

    assign din = io_in_tdata;

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_lane
            axis_l4_lane #(.LANE(k)) u_lane (
                .off       (off),
                .keep      (io_in_tkeep[k]),
                .lane_off  (lane_off[k]),
                .hit_ver   (hit_ver[k]),
                .hit_proto (hit_proto[k]),
                .hit_doff  (hit_doff[k]),
                .hit_hdr   (hit_hdr[k])
            );
            assign pay_idx[k] = lane_off[k] - hdr_end;
            assign pay_hit[k] = io_in_tkeep[k] && (lane_off[k] >= hdr_end);
        end
    endgenerate

    // Protocol byte may arrive in the same beat as later header bytes on wide buses.
    always_comb begin
        proto_eff = proto_r;
        for (int i = 0; i < NB; i++)
            if (hit_proto[i]) proto_eff = din[i];
    end

    assign hdr_end = (proto_eff == P_UDP) ? UDP_END : TCP_END;

    always_comb begin
        cnt     = '0;
        bad_now = |(io_in_tkeep & (io_in_tkeep + NB'(1)));
        for (int i = 0; i < NB; i++) begin
            cnt = cnt + 16'(io_in_tkeep[i]);
            if (hit_ver[i] && din[i] != 8'h45) bad_now = 1'b1;
            if (hit_proto[i] && din[i] != P_UDP && din[i] != P_TCP) bad_now = 1'b1;
            if (hit_doff[i] && proto_eff == P_TCP && din[i][7:4] != 4'd5) bad_now = 1'b1;
        end
    end

    assign off_sum      = {1'b0, off} + {1'b0, cnt};
    assign off_nx       = off_sum[16] ? 16'hFFFF : off_sum[15:0];
    assign bad_eff      = bad_r || bad_now;
    assign diff         = off_nx - hdr_end;
    assign io_in_tready = !reset && (state != HOLD);
    assign beat         = io_in_tvalid && io_in_tready;
    assign cap          = beat && (state == RECV);

    always_comb begin
        state_nx   = state;
        emit       = 1'b0;
        drop_inc   = 1'b0;
        release_hs = 1'b0;
        case (state)
            RECV: if (beat) begin
                if (io_in_tlast) begin
                    if (bad_eff || off_nx < hdr_end) drop_inc = 1'b1;
                    else begin
                        emit     = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (bad_eff) state_nx = DROP;
            end
            DROP: if (beat && io_in_tlast) begin
                drop_inc = 1'b1;
                state_nx = RECV;
            end
            HOLD: if ((io_out_udp_valid && io_out_udp_ready) ||
                      (io_out_tcp_valid && io_out_tcp_ready)) begin
                release_hs = 1'b1;
                state_nx   = RECV;
            end
            default: state_nx = RECV;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RECV;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off              <= '0;
            bad_r            <= 1'b0;
            proto_r          <= '0;
            hdr              <= '0;
            pay_buf          <= '0;
            trunc_r          <= 1'b0;
            len_r            <= '0;
            io_out_udp_valid <= 1'b0;
            io_out_tcp_valid <= 1'b0;
            drop_cnt         <= '0;
        end else begin
            if (beat) begin
                off   <= io_in_tlast ? '0 : off_nx;
                bad_r <= io_in_tlast ? 1'b0 : bad_eff;
            end
            if (release_hs) off <= '0;
            if (cap) begin
                if (hit_ver[0]) begin
                    pay_buf <= '0;
                    trunc_r <= 1'b0;
                end
                proto_r <= proto_eff;
                for (int i = 0; i < NB; i++) begin
                    if (hit_hdr[i]) hdr[lane_off[i][2:0] - 3'd4] <= din[i];
                    if (pay_hit[i]) begin
                        if (pay_idx[i] < MAXB) pay_buf[pay_idx[i][AW-1:0]] <= din[i];
                        else                   trunc_r <= 1'b1;
                    end
                end
            end
            if (emit) begin
                len_r            <= (diff > MAXB) ? MAXB : diff;
                io_out_udp_valid <= (proto_eff == P_UDP);
                io_out_tcp_valid <= (proto_eff == P_TCP);
            end
            if (release_hs) begin
                io_out_udp_valid <= 1'b0;
                io_out_tcp_valid <= 1'b0;
            end
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign io_out_udp_bits_data              = pay_buf;
    assign io_out_tcp_bits_data              = pay_buf;
    assign io_out_udp_bits_len               = len_r;
    assign io_out_tcp_bits_len               = len_r;
    assign io_out_udp_bits_udp_head_src_port = {hdr[0], hdr[1]};
    assign io_out_udp_bits_udp_head_dst_port = {hdr[2], hdr[3]};
    assign io_out_udp_bits_udp_head_length   = {hdr[4], hdr[5]};
    assign io_out_udp_bits_udp_head_checksum = {hdr[6], hdr[7]};
    assign io_out_tcp_bits_seq               = {hdr[4], hdr[5], hdr[6], hdr[7]};
    assign io_out_trunc                      = trunc_r;
    assign io_drop_count                     = drop_cnt;
endmodule

// File: tb/tb_axis_l4_splitter.sv
// Directed bench for axis_l4_splitter at DATA_W=32, MAX_BYTES=64.

module tb_axis_l4_splitter;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_in_tvalid = 1'b0;
    logic         io_in_tready;
    logic [31:0]  io_in_tdata = '0;
    logic [3:0]   io_in_tkeep = '0;
    logic         io_in_tlast = 1'b0;
    logic         io_out_udp_valid;
    logic         io_out_udp_ready = 1'b0;
    logic [511:0] io_out_udp_bits_data;
    logic [15:0]  io_out_udp_bits_len;
    logic [15:0]  udp_src, udp_dst, udp_length, udp_csum;
    logic         io_out_tcp_valid;
    logic         io_out_tcp_ready = 1'b0;
    logic [511:0] io_out_tcp_bits_data;
    logic [15:0]  io_out_tcp_bits_len;
    logic [31:0]  io_out_tcp_bits_seq;
    logic         io_out_trunc;
    logic [15:0]  io_drop_count;

    int passed = 0;
    int total  = 0;
    logic [7:0] pkt [0:255];

    axis_l4_splitter #(.DATA_W(32), .MAX_BYTES(64), .CNT_W(16)) dut (
        .clock                             (clock),
        .reset                             (reset),
        .io_in_tvalid                      (io_in_tvalid),
        .io_in_tready                      (io_in_tready),
        .io_in_tdata                       (io_in_tdata),
        .io_in_tkeep                       (io_in_tkeep),
        .io_in_tlast                       (io_in_tlast),
        .io_out_udp_valid                  (io_out_udp_valid),
        .io_out_udp_ready                  (io_out_udp_ready),
        .io_out_udp_bits_data              (io_out_udp_bits_data),
        .io_out_udp_bits_len               (io_out_udp_bits_len),
        .io_out_udp_bits_udp_head_src_port (udp_src),
        .io_out_udp_bits_udp_head_dst_port (udp_dst),
        .io_out_udp_bits_udp_head_length   (udp_length),
        .io_out_udp_bits_udp_head_checksum (udp_csum),
        .io_out_tcp_valid                  (io_out_tcp_valid),
        .io_out_tcp_ready                  (io_out_tcp_ready),
        .io_out_tcp_bits_data              (io_out_tcp_bits_data),
        .io_out_tcp_bits_len               (io_out_tcp_bits_len),
        .io_out_tcp_bits_seq               (io_out_tcp_bits_seq),
        .io_out_trunc                      (io_out_trunc),
        .io_drop_count                     (io_drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic build_ip(input logic [7:0] proto);
        for (int i = 0; i < 256; i++) pkt[i] = 8'h00;
        pkt[0] = 8'h45;
        pkt[9] = proto;
    endtask

    task automatic build_udp();
        build_ip(8'd17);
        pkt[20] = 8'h12; pkt[21] = 8'h34; pkt[22] = 8'h56; pkt[23] = 8'h78;
        pkt[24] = 8'h00; pkt[25] = 8'h0C; pkt[26] = 8'hBE; pkt[27] = 8'hEF;
        pkt[28] = 8'hDE; pkt[29] = 8'hAD; pkt[30] = 8'hBE; pkt[31] = 8'hEF;
    endtask

    // Sends pkt[0:n-1]; bad_beat gets tkeep=0101, tail appends an empty tlast beat.
    // Returns right after the posedge that accepts the last beat.
    task automatic send(input int n, input int bad_beat, input bit tail);
        int nbeats = (n + 3) / 4;
        int nall   = nbeats + (tail ? 1 : 0);
        for (int b = 0; b < nall; b++) begin
            int w = 0;
            @(negedge clock);
            while (!io_in_tready && w < 50) begin
                @(negedge clock);
                w++;
            end
            if (w >= 50) chk("tready_wait", {63'd0, io_in_tready}, 64'd1);
            io_in_tdata = '0;
            io_in_tkeep = '0;
            for (int k = 0; k < 4; k++)
                if (b < nbeats && b * 4 + k < n) begin
                    io_in_tdata[8*k +: 8] = pkt[b*4 + k];
                    io_in_tkeep[k] = 1'b1;
                end
            if (b == bad_beat) io_in_tkeep = 4'b0101;
            io_in_tlast  = (b == nall - 1);
            io_in_tvalid = 1'b1;
            @(posedge clock);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        io_in_tvalid = 1'b0;
        io_in_tlast  = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_tready", {63'd0, io_in_tready}, 64'd0);
        chk("rst_udp_valid", {63'd0, io_out_udp_valid}, 64'd0);
        chk("rst_drop", {48'd0, io_drop_count}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_rel_tready", {63'd0, io_in_tready}, 64'd1);

        // Basic UDP, consumer ready
        io_out_udp_ready = 1'b1;
        build_udp();
        send(32, -1, 1'b0);
        idle();
        chk("udp_valid", {63'd0, io_out_udp_valid}, 64'd1);
        chk("udp_tcp_valid", {63'd0, io_out_tcp_valid}, 64'd0);
        chk("udp_src", {48'd0, udp_src}, 64'h1234);
        chk("udp_dst", {48'd0, udp_dst}, 64'h5678);
        chk("udp_length", {48'd0, udp_length}, 64'h000C);
        chk("udp_csum", {48'd0, udp_csum}, 64'hBEEF);
        chk("udp_len", {48'd0, io_out_udp_bits_len}, 64'd4);
        chk("udp_data", io_out_udp_bits_data[63:0], 64'h0000_0000_EFBE_ADDE);
        chk("udp_trunc", {63'd0, io_out_trunc}, 64'd0);
        @(negedge clock);
        chk("udp_done_valid", {63'd0, io_out_udp_valid}, 64'd1 - 64'd1);
        chk("udp_done_tready", {63'd0, io_in_tready}, 64'd1);

        // Backpressure: ready low for 5 cycles
        io_out_udp_ready = 1'b0;
        send(32, -1, 1'b0);
        idle();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {63'd0, io_out_udp_valid}, 64'd1);
            chk("bp_tready", {63'd0, io_in_tready}, 64'd0);
            chk("bp_bits", {io_out_udp_bits_len, udp_src, io_out_udp_bits_data[31:0]},
                64'h0004_1234_EFBE_ADDE);
            @(negedge clock);
        end
        io_out_udp_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_valid", {63'd0, io_out_udp_valid}, 64'd0);
        chk("bp_release_tready", {63'd0, io_in_tready}, 64'd1);

        // TCP with 70-byte payload -> truncated to 64; udp_ready must be ignored
        build_ip(8'd6);
        pkt[24] = 8'h01; pkt[25] = 8'h02; pkt[26] = 8'h03; pkt[27] = 8'h04;
        pkt[32] = 8'h50;
        for (int i = 0; i < 70; i++) pkt[40 + i] = 8'(i * 3 + 1);
        io_out_tcp_ready = 1'b0;
        send(110, -1, 1'b0);
        idle();
        chk("tcp_valid", {63'd0, io_out_tcp_valid}, 64'd1);
        chk("tcp_udp_valid", {63'd0, io_out_udp_valid}, 64'd0);
        chk("tcp_seq", {32'd0, io_out_tcp_bits_seq}, 64'h0102_0304);
        chk("tcp_len", {48'd0, io_out_tcp_bits_len}, 64'd64);
        chk("tcp_trunc", {63'd0, io_out_trunc}, 64'd1);
        chk("tcp_byte0", {56'd0, io_out_tcp_bits_data[7:0]}, 64'h01);
        chk("tcp_byte63", {56'd0, io_out_tcp_bits_data[511:504]}, 64'hBE);
        @(negedge clock);
        chk("tcp_other_ready", {63'd0, io_out_tcp_valid}, 64'd1);
        io_out_tcp_ready = 1'b1;
        @(negedge clock);
        chk("tcp_release", {63'd0, io_out_tcp_valid}, 64'd0);

        // ICMP dropped, then UDP back-to-back
        build_ip(8'd1);
        send(32, -1, 1'b0);
        build_udp();
        send(32, -1, 1'b0);
        idle();
        chk("icmp_drop", {48'd0, io_drop_count}, 64'd1);
        chk("b2b_udp_valid", {63'd0, io_out_udp_valid}, 64'd1);
        chk("b2b_udp_dst", {48'd0, udp_dst}, 64'h5678);
        @(negedge clock);

        // Runt UDP
        build_udp();
        send(24, -1, 1'b0);
        idle();
        chk("runt_drop", {48'd0, io_drop_count}, 64'd2);
        chk("runt_no_valid", {62'd0, io_out_udp_valid, io_out_tcp_valid}, 64'd0);

        // Non-contiguous tkeep
        send(32, 3, 1'b0);
        idle();
        chk("keep_drop", {48'd0, io_drop_count}, 64'd3);
        chk("keep_no_valid", {62'd0, io_out_udp_valid, io_out_tcp_valid}, 64'd0);

        // Empty tlast beat terminates the packet without adding bytes
        send(32, -1, 1'b1);
        idle();
        chk("tail_valid", {63'd0, io_out_udp_valid}, 64'd1);
        chk("tail_len", {48'd0, io_out_udp_bits_len}, 64'd4);
        chk("tail_data", io_out_udp_bits_data[63:0], 64'h0000_0000_EFBE_ADDE);
        @(negedge clock);

        // Reset while holding a result
        io_out_udp_ready = 1'b0;
        send(32, -1, 1'b0);
        idle();
        chk("hold_valid", {63'd0, io_out_udp_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("hrst_valid", {63'd0, io_out_udp_valid}, 64'd0);
        chk("hrst_tready", {63'd0, io_in_tready}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("hrst_rel_tready", {63'd0, io_in_tready}, 64'd1);
        chk("hrst_drop", {48'd0, io_drop_count}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axis_l4_splitter.md
Name: axis_l4_splitter

Overview:
- Parametrised successor to the fixed 32-bit AXI-Stream UDP/TCP analyser.
- Accepts IPv4 packets (first byte = IPv4 version/IHL) on one AXI-Stream input of configurable width.
- Parses the IPv4 and L4 headers, collects the payload into a MAX_BYTES buffer and presents it on a UDP or TCP output channel with decoded header fields.
- Drops malformed or unsupported packets and counts them. Sits between the MAC RX stream and the protocol engines.

Parameters:
- DATA_W, 32, input tdata width in bits; multiple of 8, range 8..512.
- MAX_BYTES, 64, payload buffer depth in bytes; data outputs are 8*MAX_BYTES bits wide.
- CNT_W, 16, width of the drop counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- io_in_tvalid  in  1  input beat valid.
- io_in_tready  out  1  input ready.
- io_in_tdata  in  DATA_W  byte k = bits [8k+7:8k]; k=0 is first on the wire.
- io_in_tkeep  in  DATA_W/8  byte enables.
- io_in_tlast  in  1  last beat of packet.
- io_out_udp_valid  out  1  UDP result valid.
- io_out_udp_ready  in  1  UDP consumer ready.
- io_out_udp_bits_data  out  8*MAX_BYTES  payload; payload byte i at bits [8i+7:8i], unused bytes 0.
- io_out_udp_bits_len  out  16  captured payload byte count.
- io_out_udp_bits_udp_head_src_port / dst_port / length / checksum  out  16 each  UDP header fields, big-endian decoded.
- io_out_tcp_valid  out  1  TCP result valid.
- io_out_tcp_ready  in  1  TCP consumer ready.
- io_out_tcp_bits_data  out  8*MAX_BYTES  payload, same packing as UDP.
- io_out_tcp_bits_len  out  16  captured payload byte count.
- io_out_tcp_bits_seq  out  32  TCP sequence number.
- io_out_trunc  out  1  current result was truncated at MAX_BYTES.
- io_drop_count  out  CNT_W  saturating count of dropped packets.

Behaviour:
- States: RECV, HOLD, DROP.
- Reset (asynchronous): state=RECV; all valids 0; data/len/header/seq/trunc registers 0; byte offset 0; io_drop_count 0. io_in_tready=0 while reset is high.
- io_in_tready=1 in RECV and DROP, 0 in HOLD.
- Each accepted beat, kept bytes are numbered by a running packet byte offset `off` (16-bit, saturating at 0xFFFF). Only lanes with tkeep=1 advance `off`; tkeep must be low-contiguous. A non-contiguous tkeep marks the packet bad.
- Byte capture by offset:
  - off 0 checked: must equal 0x45 (IPv4, IHL=5), else bad.
  - off 9 = protocol: 17 = UDP, 6 = TCP, else bad.
  - UDP: off 20-27 = src, dst, length, checksum.
  - TCP: off 24-27 = seq; off 32 upper nibble must equal 5, else bad.
  - Payload starts at off 28 (UDP) or 40 (TCP). Payload byte i written to buffer byte i if i < MAX_BYTES; otherwise trunc=1 and the byte is discarded.
- Buffer bytes are cleared to 0 at the start of every packet (off 0 accepted), so unused bytes read 0.
- Once the packet is marked bad before tlast, go to DROP. DROP consumes beats until tlast, then increments io_drop_count and returns to RECV.
- On the tlast beat in RECV:
  - If bad, or off < header end (runt: <28 UDP, <40 TCP): increment io_drop_count and stay in RECV.
  - Otherwise: len = min(off - header end, MAX_BYTES). Next cycle assert the matching valid and enter HOLD. Latency is 1 cycle after the accepted tlast beat.
- HOLD: valid and all bits are stable until the matching ready is high on a rising edge. That cycle valid drops, off is reset and state returns to RECV. tready is high the following cycle.
- Only one output valid is ever high. The ready of the non-selected channel is ignored.
- A tlast beat with all tkeep=0 adds no bytes but still terminates the packet.
- io_drop_count saturates at all-ones.
- Reset mid-packet or in HOLD: the partial result is discarded and valid is cleared at once. No drop is counted.

Test Plan:
- DATA_W=32: UDP packet, IPv4 0x45, proto 17, ports 0x1234→0x5678, length 0x000C, checksum 0xBEEF, payload DE AD BE EF over 8 beats → 1 cycle after tlast: udp_valid=1, src=0x1234, dst=0x5678, len=4, data[31:0]=0xEFBEADDE, trunc=0.
- Same UDP packet with udp_ready held 0 for 5 cycles → valid and bits stable, tready=0 throughout; handshake on cycle 6, tready=1 next cycle.
- TCP packet, seq 0x01020304, data offset 5, 70-byte payload → tcp_valid=1, seq=0x01020304, len=64, trunc=1, data byte 63 = payload byte 63.
- Protocol 1 (ICMP) packet, then a valid UDP packet back-to-back → first dropped (drop_count=1, no valid), second reported normally.
- 24-byte UDP runt, and a packet with tkeep=4'b0101 mid-stream → each dropped, drop_count increments by 1 per packet.
- Reset asserted in HOLD with udp_valid=1 → udp_valid=0 and tready=0 immediately; after release tready=1 and drop_count=0.
